// File: rtl/i_type_pkg.sv
// Shared constants for the LEGv8 I-type ALU control unit:
// opcodes, ALU function selects, FSM states and control-word layout.
package i_type_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ISSUE
  } state_e;

  localparam logic [9:0] OP_ADDI  = 10'b1001000100;
  localparam logic [9:0] OP_ADDIS = 10'b1011000100;
  localparam logic [9:0] OP_SUBI  = 10'b1101000100;
  localparam logic [9:0] OP_SUBIS = 10'b1111000100;
  localparam logic [9:0] OP_ANDI  = 10'b1001001000;
  localparam logic [9:0] OP_ANDIS = 10'b1111001000;
  localparam logic [9:0] OP_ORRI  = 10'b1011001000;
  localparam logic [9:0] OP_EORI  = 10'b1101001000;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_XOR = 5'b01100;

  localparam logic [1:0] PSEL_ALU  = 2'b01;
  localparam logic [1:0] SEQ_FETCH = 2'b00;
  localparam logic [4:0] REG_XZR   = 5'd31;

  localparam int CW_W      = 31;
  localparam int CW_SL     = 0;
  localparam int CW_PCSEL  = 1;
  localparam int CW_BSEL   = 2;
  localparam int CW_EN_PC  = 3;
  localparam int CW_EN_B   = 4;
  localparam int CW_EN_ALU = 5;
  localparam int CW_EN_MEM = 6;
  localparam int CW_RAMW   = 7;
  localparam int CW_REGW   = 8;
  localparam int CW_FSEL   = 9;
  localparam int CW_SB     = 14;
  localparam int CW_SA     = 19;
  localparam int CW_DA     = 24;
  localparam int CW_PSEL   = 29;

endpackage

// File: rtl/i_type_decode.sv
// Combinational I-type decoder: opcode to control word,
// plus the zero-extended immediate K.
module i_type_decode
  import i_type_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 12
) (
  input  logic [31:0]       instruction,
  output logic [CW_W-1:0]   controlword,
  output logic [DATA_W-1:0] K,
  output logic              legal
);

  logic [9:0] op;
  logic [4:0] fsel;
  logic       sl;

  assign op = instruction[31:22];
  assign K  = DATA_W'(instruction[IMM_W+9:10]);

  always_comb begin
    legal       = 1'b0;
    fsel        = '0;
    sl          = 1'b0;
    controlword = '0;
    unique case (1'b1)
      (op == OP_ADDI): begin
        legal = 1'b1;
        fsel  = FS_ADD;
      end
      (op == OP_ADDIS): begin
        legal = 1'b1;
        fsel  = FS_ADD;
        sl    = 1'b1;
      end
      (op == OP_SUBI): begin
        legal = 1'b1;
        fsel  = FS_SUB;
      end
      (op == OP_SUBIS): begin
        legal = 1'b1;
        fsel  = FS_SUB;
        sl    = 1'b1;
      end
      (op == OP_ANDI): begin
        legal = 1'b1;
        fsel  = FS_AND;
      end
      (op == OP_ANDIS): begin
        legal = 1'b1;
        fsel  = FS_AND;
        sl    = 1'b1;
      end
      (op == OP_ORRI): begin
        legal = 1'b1;
        fsel  = FS_OR;
      end
      (op == OP_EORI): begin
        legal = 1'b1;
        fsel  = FS_XOR;
      end
      default: ;
    endcase
    if (legal) begin
      controlword[CW_PSEL+:2] = PSEL_ALU;
      controlword[CW_DA+:5]   = instruction[4:0];
      controlword[CW_SA+:5]   = instruction[9:5];
      controlword[CW_SB+:5]   = REG_XZR;
      controlword[CW_FSEL+:5] = fsel;
      controlword[CW_REGW]    = 1'b1;
      controlword[CW_EN_ALU]  = 1'b1;
      controlword[CW_BSEL]    = 1'b1;
      controlword[CW_SL]      = sl;
    end
  end

endmodule

// File: rtl/i_type_control_fsm.sv
// Three-state control FSM for LEGv8 I-type ALU ops: accept,
// decode into registers, then hold the control word until taken.
module i_type_control_fsm
  import i_type_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic              ctl_valid,
  input  logic              ctl_ready,
  output logic [CW_W-1:0]   controlword,
  output logic [DATA_W-1:0] K,
  output logic              flag_we,
  output logic              illegal,
  output logic [1:0]        next_state,
  output logic [CNT_W-1:0]  retired_count,
  output logic [CNT_W-1:0]  illegal_count
);

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [DATA_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [CNT_W-1:0]    ill_q, ill_d;

  logic [CW_W-1:0]     dec_cw;
  logic [DATA_W-1:0]   dec_k;
  logic                dec_legal;

  i_type_decode #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .instruction (instr_q),
    .controlword (dec_cw),
    .K           (dec_k),
    .legal       (dec_legal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      cw_q    <= '0;
      k_q     <= '0;
      ret_q   <= '0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cw_q    <= cw_d;
      k_q     <= k_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
    end
  end

  // Strobes are gated by reset_n so an aborted op leaves no trace.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    cw_d        = cw_q;
    k_d         = k_q;
    ret_d       = ret_q;
    ill_d       = ill_q;
    instr_ready = 1'b0;
    ctl_valid   = 1'b0;
    controlword = '0;
    flag_we     = 1'b0;
    illegal     = 1'b0;
    next_state  = SEQ_FETCH;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          cw_d    = dec_cw;
          k_d     = dec_k;
          state_d = ISSUE;
        end else begin
          illegal = reset_n;
          ill_d   = ill_q + 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        ctl_valid   = 1'b1;
        controlword = cw_q;
        if (ctl_ready) begin
          flag_we = cw_q[CW_SL] & reset_n;
          ret_d   = ret_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign K             = k_q;
  assign retired_count = ret_q;
  assign illegal_count = ill_q;

endmodule

// File: tb/tb_i_type_control_fsm.sv
// Directed bench for i_type_control_fsm (64-bit and 32-bit builds).
// Checks handshakes, control words, counters, reset abort.
module tb_i_type_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [31:0] instr;
  logic        crdy;

  logic        ir, cv, fwe, ill;
  logic [30:0] cw;
  logic [63:0] k;
  logic [1:0]  ns;
  logic [15:0] rc, ic;

  logic        ir32, cv32, fwe32, ill32;
  logic [30:0] cw32;
  logic [31:0] k32;
  logic [1:0]  ns32;
  logic [15:0] rc32, ic32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i_type_control_fsm dut (
    .clock         (clk),
    .reset_n       (rst_n),
    .instr_valid   (iv),
    .instr_ready   (ir),
    .instruction   (instr),
    .ctl_valid     (cv),
    .ctl_ready     (crdy),
    .controlword   (cw),
    .K             (k),
    .flag_we       (fwe),
    .illegal       (ill),
    .next_state    (ns),
    .retired_count (rc),
    .illegal_count (ic)
  );

  i_type_control_fsm #(.DATA_W(32)) dut32 (
    .clock         (clk),
    .reset_n       (rst_n),
    .instr_valid   (iv),
    .instr_ready   (ir32),
    .instruction   (instr),
    .ctl_valid     (cv32),
    .ctl_ready     (crdy),
    .controlword   (cw32),
    .K             (k32),
    .flag_we       (fwe32),
    .illegal       (ill32),
    .next_state    (ns32),
    .retired_count (rc32),
    .illegal_count (ic32)
  );

  function automatic logic [31:0] enc(
    input logic [9:0]  op,
    input logic [11:0] imm,
    input logic [4:0]  rn,
    input logic [4:0]  rd
  );
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [30:0] cwx(
    input logic [4:0] da,
    input logic [4:0] sa,
    input logic [4:0] f,
    input logic       sl
  );
    return {2'b01, da, sa, 5'd31, f,
            1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
            1'b0, 1'b1, 1'b0, sl};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] w;
  logic [31:0] seq [3];
  logic [4:0]  fs  [3];

  initial begin
    rst_n = 1'b0;
    iv    = 1'b0;
    instr = '0;
    crdy  = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(ir), 1);
    chk("rst_cv", 64'(cv), 0);
    chk("rst_cw", 64'(cw), 0);
    chk("rst_k", k, 0);
    chk("rst_fwe", 64'(fwe), 0);
    chk("rst_ill", 64'(ill), 0);
    chk("rst_ns", 64'(ns), 0);
    chk("rst_cnt", 64'({rc, ic}), 0);
    rst_n = 1'b1;
    tick();

    // ADDI X3,X7,#0x123 with ctl_ready high
    instr = 32'h9104_8CE3;
    iv    = 1'b1;
    #1;
    chk("addi_ready", 64'(ir), 1);
    tick();
    iv = 1'b0;
    #1;
    chk("addi_dec_ready", 64'(ir), 0);
    chk("addi_dec_cv", 64'(cv), 0);
    chk("addi_dec_cw", 64'(cw), 0);
    tick();
    chk("addi_cv", 64'(cv), 1);
    chk("addi_cw_lit", 64'(cw), 64'h233F_D124);
    chk("addi_cw", 64'(cw), 64'(cwx(3, 7, 5'b01000, 0)));
    chk("addi_k", k, 64'h123);
    chk("addi_fwe", 64'(fwe), 0);
    tick();
    chk("addi_done_cv", 64'(cv), 0);
    chk("addi_ret", 64'(rc), 1);
    chk("addi_idle", 64'(ir), 1);
    chk("addi_fwe_after", 64'(fwe), 0);

    // SUBIS X1,X2,#0xFFF with ctl_ready stalled
    crdy  = 1'b0;
    instr = 32'hF13F_FC41;
    iv    = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("subis_stall_cv", 64'(cv), 1);
      chk("subis_stall_cw", 64'(cw),
          64'(cwx(1, 2, 5'b01001, 1)));
      chk("subis_stall_fwe", 64'(fwe), 0);
      chk("subis_stall_ir", 64'(ir), 0);
      tick();
    end
    crdy = 1'b1;
    #1;
    chk("subis_fwe", 64'(fwe), 1);
    chk("subis_fsel", 64'(cw[13:9]), 64'b01001);
    chk("subis_k", k, 64'hFFF);
    chk("subis_ill", 64'(ill), 0);
    tick();
    chk("subis_fwe_off", 64'(fwe), 0);
    chk("subis_cv_off", 64'(cv), 0);
    chk("subis_ret", 64'(rc), 2);

    // R-type ADD is rejected
    instr = 32'h8B02_0020;
    iv    = 1'b1;
    tick();
    iv = 1'b0;
    #1;
    chk("ill_pulse", 64'(ill), 1);
    chk("ill_cv", 64'(cv), 0);
    chk("ill_fwe", 64'(fwe), 0);
    chk("ill_ns", 64'(ns), 0);
    tick();
    chk("ill_pulse_off", 64'(ill), 0);
    chk("ill_cv_off", 64'(cv), 0);
    chk("ill_idle", 64'(ir), 1);
    chk("ill_cnt", 64'(ic), 1);
    chk("ill_ret", 64'(rc), 2);

    // back-to-back ANDI, ORRI, EORI from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("b2b_rst_cnt", 64'({rc, ic}), 0);
    seq[0] = enc(10'b1001001000, 12'h00F, 5'd4, 5'd5);
    seq[1] = enc(10'b1011001000, 12'hA5A, 5'd6, 5'd7);
    seq[2] = enc(10'b1101001000, 12'h001, 5'd8, 5'd31);
    fs[0]  = 5'b00000;
    fs[1]  = 5'b00100;
    fs[2]  = 5'b01100;
    iv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = seq[i];
      #1;
      chk("b2b_idle_ir", 64'(ir), 1);
      tick();
      chk("b2b_dec_ir", 64'(ir), 0);
      tick();
      chk("b2b_iss_ir", 64'(ir), 0);
      chk("b2b_cv", 64'(cv), 1);
      chk("b2b_fsel", 64'(cw[13:9]), 64'(fs[i]));
      chk("b2b_da", 64'(cw[28:24]), 64'(seq[i][4:0]));
      chk("b2b_k", k, 64'(seq[i][21:10]));
      tick();
    end
    iv = 1'b0;
    chk("b2b_ret", 64'(rc), 3);
    chk("b2b_ill", 64'(ic), 0);

    // reset while an ADDIS sits in ISSUE
    crdy  = 1'b0;
    instr = enc(10'b1011000100, 12'h321, 5'd9, 5'd10);
    iv    = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    chk("rsti_cv", 64'(cv), 1);
    chk("rsti_sl", 64'(cw[0]), 1);
    rst_n = 1'b0;
    crdy  = 1'b1;
    #1;
    chk("rsti_fwe_during", 64'(fwe), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rsti_ir", 64'(ir), 1);
    chk("rsti_cw", 64'(cw), 0);
    chk("rsti_cv", 64'(cv), 0);
    chk("rsti_fwe", 64'(fwe), 0);
    chk("rsti_cnt", 64'({rc, ic}), 0);
    tick();
    chk("rsti_fwe_next", 64'(fwe), 0);
    chk("rsti_cv_next", 64'(cv), 0);

    // ADDI #0x800: K must be zero-extended in both widths
    w     = enc(10'b1001000100, 12'h800, 5'd5, 5'd1);
    instr = w;
    iv    = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    chk("zx_cv32", 64'(cv32), 1);
    chk("zx_k32", 64'(k32), 64'h0000_0800);
    chk("zx_k64", k, 64'h800);
    chk("zx_cw32", 64'(cw32),
        64'(cwx(1, 5, 5'b01000, 0)));
    tick();
    chk("zx_ret32", 64'(rc32), 1);
    chk("zx_ret64", 64'(rc), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
